// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer
//   Control FSM for a chain of NUM_DIGITS cascaded digit counters (digit 0 is
//   the least significant). Produces the prescaled count tick, the per-digit
//   cascade enables, the shared count direction and the digit clear, and uses
//   the counters' threshold flags to detect carry/borrow and terminal count.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous reset, active-low
//   start_stop      one-cycle pulse: start / pause / resume
//   clear           one-cycle pulse: back to IDLE, reload the digits
//   lap             one-cycle pulse: toggle display freeze (RUNNING/PAUSED)
//   mode_down       level, 1 = count down; sampled only in IDLE
//   digit_threshold per-digit flag: digit at BASE-1 (up) or at 0 (down)
//   digit_enable    per-digit count enable
//   up_down         count direction to every digit, 1 = up
//   digit_clear     registered clear to every digit counter
//   display_freeze  holds the display latch while high
//   done            high while in DONE
//   state           IDLE=00, RUNNING=01, PAUSED=10, DONE=11
module stopwatch_sequencer #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIVISOR = 1000000,
  parameter int DIV_BITS     = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic                  mode_down,
  input  logic [NUM_DIGITS-1:0] digit_threshold,
  output logic [NUM_DIGITS-1:0] digit_enable,
  output logic                  up_down,
  output logic                  digit_clear,
  output logic                  display_freeze,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [DIV_BITS-1:0] PRE_LAST = DIV_BITS'(TICK_DIVISOR - 1);

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] pre_q, pre_d;
  logic                up_down_q, up_down_d;
  logic                clr_q, clr_d;
  logic                frz_q, frz_d;
  logic                done_q, done_d;
  logic                tick;
  logic                terminal;

  // Cascade: a digit advances on a tick only when every lower digit sits at
  // its threshold. At terminal count all enables are withheld so the chain
  // saturates instead of wrapping.
  always_comb begin
    logic carry;
    terminal = &digit_threshold;
    tick     = (state_q == S_RUN) && (pre_q == PRE_LAST);
    carry    = tick & ~terminal;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_enable[i] = carry;
      carry           = carry & digit_threshold[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    up_down_d = up_down_q;
    frz_d     = frz_q;

    case (state_q)
      S_IDLE:  if (start_stop) state_d = S_RUN;
      S_RUN: begin
        if (start_stop)             state_d = S_PAUSE;
        else if (tick && terminal)  state_d = S_DONE;
      end
      S_PAUSE: if (start_stop) state_d = S_RUN;
      default: state_d = S_DONE;
    endcase
    if (clear) state_d = S_IDLE;

    // Prescaler advances on the current state, so a pause still completes
    // the count of the cycle it arrives in; PAUSED keeps the partial period.
    case (state_q)
      S_RUN:   pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + DIV_BITS'(1);
      S_PAUSE: pre_d = pre_q;
      default: pre_d = '0;
    endcase
    if (clear) pre_d = '0;

    // Direction tracks mode_down only while idle; a change forces a reload
    // so the digits start from 0 (up) or BASE-1 (down).
    if (state_q == S_IDLE) up_down_d = ~mode_down;
    clr_d = clear || ((state_q == S_IDLE) && (up_down_q != ~mode_down));

    if ((state_d == S_IDLE) || (state_d == S_DONE))
      frz_d = 1'b0;
    else if (lap && ((state_q == S_RUN) || (state_q == S_PAUSE)))
      frz_d = ~frz_q;

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      up_down_q <= 1'b1;
      clr_q     <= 1'b1;
      frz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      up_down_q <= up_down_d;
      clr_q     <= clr_d;
      frz_q     <= frz_d;
      done_q    <= done_d;
    end
  end

  assign up_down        = up_down_q;
  assign digit_clear    = clr_q;
  assign display_freeze = frz_q;
  assign done           = done_q;
  assign state          = state_q;

endmodule
